gpr_debug_master: RTL and testbench

//  Debug-side initiator for the 32x32 GPR file: accepts read/write burst commands, halts the core,

---
 rtl/gpr_debug_master.sv | 169 ++++++++++++++++
 tb/tb_gpr_debug_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_debug_master.sv
// rtl/gpr_debug_master.sv - debug initiator that halts the core and runs GPR read/write bursts
// Owns the GPR file ports only while halted=1; any loss of halt aborts the command with an error.
module gpr_debug_master #(
    parameter int HALT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_addr,
    input  logic [4:0]  cmd_len,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_err,
    output logic [31:0] rsp_data,
    output logic        halt_req,
    input  logic        halted,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        rf_re,
    output logic [4:0]  rf_raddr,
    input  logic [31:0] rf_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_HALT_WAIT, S_RD, S_RD_RSP, S_WR, S_ACK, S_ERR
    } state_t;

    state_t      r_state;
    logic        r_write;
    logic [4:0]  r_cur;
    logic [4:0]  r_rem;
    logic [15:0] r_timer;

    logic [5:0]  w_end;
    logic [15:0] w_timer_nxt;

    assign w_end       = {1'b0, cmd_addr} + {1'b0, cmd_len};
    assign w_timer_nxt = r_timer + 16'd1;

    // Port access is gated by halted so nothing touches the GPR file once halt is lost.
    assign cmd_ready = (r_state == S_IDLE);
    assign wr_ready  = (r_state == S_WR) && halted;
    assign rf_re     = (r_state == S_RD) && halted;
    assign rf_raddr  = rf_re ? r_cur : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_cur     <= 5'd0;
            r_rem     <= 5'd0;
            r_timer   <= 16'd0;
            halt_req  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= 32'd0;
            rf_we     <= 1'b0;
            rf_waddr  <= 5'd0;
            rf_wdata  <= 32'd0;
        end else begin
            rf_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_write <= cmd_write;
                        r_cur   <= cmd_addr;
                        r_rem   <= cmd_len;
                        r_timer <= 16'd0;
                        if (w_end > 6'd31) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= 32'd1;
                            r_state   <= S_ERR;
                        end else begin
                            halt_req <= 1'b1;
                            r_state  <= S_HALT_WAIT;
                        end
                    end
                end
                S_HALT_WAIT: begin
                    if (halted) begin
                        r_state <= r_write ? S_WR : S_RD;
                    end else if (w_timer_nxt == 16'(HALT_TIMEOUT)) begin
                        halt_req  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= 32'd2;
                        r_state   <= S_ERR;
                    end else begin
                        r_timer <= w_timer_nxt;
                    end
                end
                S_RD: begin
                    rsp_valid <= 1'b1;
                    if (!halted) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= 32'd3;
                        r_state  <= S_ERR;
                    end else begin
                        rsp_err  <= 1'b0;
                        rsp_data <= rf_rdata;
                        r_state  <= S_RD_RSP;
                    end
                end
                S_RD_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (r_rem == 5'd0) begin
                            halt_req <= 1'b0;
                            r_state  <= S_IDLE;
                        end else begin
                            r_cur   <= r_cur + 5'd1;
                            r_rem   <= r_rem - 5'd1;
                            r_state <= S_RD;
                        end
                    end else if (!halted) begin
                        // Undelivered read data is replaced by the error response.
                        rsp_err  <= 1'b1;
                        rsp_data <= 32'd3;
                        r_state  <= S_ERR;
                    end
                end
                S_WR: begin
                    if (!halted) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= 32'd3;
                        r_state   <= S_ERR;
                    end else if (wr_valid) begin
                        rf_we    <= 1'b1;
                        rf_waddr <= r_cur;
                        rf_wdata <= wr_data;
                        if (r_rem == 5'd0) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_data  <= 32'd0;
                            r_state   <= S_ACK;
                        end else begin
                            r_cur <= r_cur + 5'd1;
                            r_rem <= r_rem - 5'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        halt_req  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                S_ERR: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_data  <= 32'd0;
                        halt_req  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpr_debug_master.sv
// tb/tb_gpr_debug_master.sv - directed bench for gpr_debug_master with GPR file and halt model
module tb_gpr_debug_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_addr, cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        halt_req, halted;
    logic        rf_we, rf_re;
    logic [4:0]  rf_waddr, rf_raddr;
    logic [31:0] rf_wdata, rf_rdata;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    gpr_debug_master #(.HALT_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .halt_req(halt_req), .halted(halted),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata)
    );

    // Core halts 3 cycles after halt_req; force_low models a core that never halts or resumes.
    logic       auto_halted;
    logic [1:0] hcnt;
    logic       force_low;
    assign halted = auto_halted & ~force_low;
    always @(posedge clk) begin
        if (rst || !halt_req) begin
            auto_halted <= 1'b0;
            hcnt        <= 2'd0;
        end else if (hcnt == 2'd2) auto_halted <= 1'b1;
        else hcnt <= hcnt + 2'd1;
    end

    logic [31:0] regs [32];
    assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 32; i++) regs[i] <= 32'(32'h11 * (i - 4));
        else if (rf_we) regs[rf_waddr] <= rf_wdata;
    end

    int         cyc = 0;
    int         we_total = 0, re_total = 0, hr_total = 0, viol = 0;
    logic [4:0] we_addr [64];
    int         we_cyc [64];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (halt_req) hr_total <= hr_total + 1;
        if (rf_re) re_total <= re_total + 1;
        if (rf_we) begin
            we_addr[we_total[5:0]] <= rf_waddr;
            we_cyc[we_total[5:0]]  <= cyc;
            we_total <= we_total + 1;
        end
        if ((rf_we && rf_re) || (rf_we && !halted) || (rf_re && !halted)) viol <= viol + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic w, input logic [4:0] a, input logic [4:0] l);
        int n = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        check("cmd_wait", {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_wr(input logic [31:0] d0, input logic [31:0] d1, input int nb);
        for (int b = 0; b < nb; b++) begin
            int n = 0;
            wr_valid = 1'b1;
            wr_data  = (b == 0) ? d0 : d1;
            while (!wr_ready && n < 50) begin @(negedge clk); n++; end
            check("wr_wait", {31'd0, wr_ready}, 32'd1);
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    int rsp_cyc;
    task automatic get_rsp(input int stall, output logic e, output logic [31:0] d);
        int n = 0;
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        check("rsp_wait", {31'd0, rsp_valid}, 32'd1);
        rsp_cyc = cyc;
        e = rsp_err;
        d = rsp_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("stall_data", rsp_data, d);
            check("stall_valid", {31'd0, rsp_valid}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    logic        e;
    logic [31:0] d;
    int          we0, re0, hr0, c0;

    initial begin
        rst = 1'b1; force_low = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 5'd0; cmd_len = 5'd0;
        wr_valid = 1'b0; wr_data = 32'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_outs", {26'd0, halt_req, rsp_valid, rsp_err, rf_we, rf_re, wr_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Read x5..x7 with a 4-cycle stall on beat 2
        send_cmd(1'b0, 5'd5, 5'd2);
        get_rsp(0, e, d);
        check("rd0_err", {31'd0, e}, 32'd0);
        check("rd0_data", d, 32'h11);
        get_rsp(4, e, d);
        check("rd1_data", d, 32'h22);
        check("rd1_halt_req", {31'd0, halt_req}, 32'd1);
        get_rsp(0, e, d);
        check("rd2_data", d, 32'h33);
        check("rd2_halt_req", {31'd0, halt_req}, 32'd0);

        // Back-to-back write to x30,x31 then readback
        we0 = we_total;
        send_cmd(1'b1, 5'd30, 5'd1);
        send_wr(32'hDEADBEEF, 32'h12345678, 2);
        get_rsp(0, e, d);
        check("wr_ack_err", {31'd0, e}, 32'd0);
        check("wr_ack_data", d, 32'd0);
        check("wr_pulses", 32'(we_total - we0), 32'd2);
        check("wr_addr0", {27'd0, we_addr[we0[5:0]]}, 32'd30);
        check("wr_addr1", {27'd0, we_addr[we0[5:0] + 6'd1]}, 32'd31);
        check("wr_b2b", 32'(we_cyc[we0[5:0] + 6'd1] - we_cyc[we0[5:0]]), 32'd1);
        send_cmd(1'b0, 5'd30, 5'd1);
        get_rsp(0, e, d);
        check("rb30", d, 32'hDEADBEEF);
        get_rsp(0, e, d);
        check("rb31", d, 32'h12345678);

        // Range error: 31+1 overflows the register file
        we0 = we_total; re0 = re_total; hr0 = hr_total;
        send_cmd(1'b0, 5'd31, 5'd1);
        get_rsp(0, e, d);
        check("range_err", {31'd0, e}, 32'd1);
        check("range_code", d, 32'd1);
        check("range_no_access", 32'((we_total - we0) + (re_total - re0) + (hr_total - hr0)), 32'd0);

        // Halt timeout after 8 wait cycles
        force_low = 1'b1;
        send_cmd(1'b0, 5'd1, 5'd0);
        c0 = cyc;
        get_rsp(0, e, d);
        check("tmo_err", {31'd0, e}, 32'd1);
        check("tmo_code", d, 32'd2);
        check("tmo_cycles", 32'(rsp_cyc - c0), 32'd8);
        force_low = 1'b0;
        check("tmo_halt_req", {31'd0, halt_req}, 32'd0);

        // Halt lost after the second write beat
        we0 = we_total;
        send_cmd(1'b1, 5'd10, 5'd3);
        send_wr(32'hA0A0A0A0, 32'hB1B1B1B1, 2);
        @(negedge clk);
        force_low = 1'b1;
        get_rsp(0, e, d);
        check("lost_err", {31'd0, e}, 32'd1);
        check("lost_code", d, 32'd3);
        check("lost_pulses", 32'(we_total - we0), 32'd2);
        check("lost_halt_req", {31'd0, halt_req}, 32'd0);
        force_low = 1'b0;

        // Reset while a read response is pending
        send_cmd(1'b0, 5'd5, 5'd1);
        begin
            int n = 0;
            while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
        end
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {26'd0, halt_req, rsp_valid, rsp_err, rf_we, rf_re, wr_ready}, 32'd0);
        check("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("mid_rst_data", rsp_data | rf_wdata | {22'd0, rf_waddr, rf_raddr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        send_cmd(1'b0, 5'd5, 5'd0);
        get_rsp(0, e, d);
        check("post_rst_err", {31'd0, e}, 32'd0);
        check("post_rst_data", d, 32'h11);

        repeat (2) @(negedge clk);
        check("port_rules", 32'(viol), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
